// File: rtl/demux_lanes_1a2.sv
// Two-lane word distributor: deals valid words alternately onto lane 0 / lane 1.
// Define DEMUX_PAIR_ALIGN_EN to release lane words as aligned pairs (lane 0 word held).
module demux_lanes_1a2 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              active,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic              sel,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, EXP0, EXP1} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] stg_d0_q, stg_d0_d, stg_d1_q, stg_d1_d;
  logic              stg_v0_q, stg_v0_d, stg_v1_q, stg_v1_d;
  logic [DATA_W-1:0] lane_0_q, lane_0_d, lane_1_q, lane_1_d;
  logic              valid_0_q, valid_0_d, valid_1_q, valid_1_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]        drop_inc;
  logic [CNT_W:0]    drop_sum;
`ifdef DEMUX_PAIR_ALIGN_EN
  logic [DATA_W-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d  = state_q;
    stg_d0_d = stg_d0_q;
    stg_d1_d = stg_d1_q;
    stg_v0_d = 1'b0;
    stg_v1_d = 1'b0;
    drop_inc = 2'd0;
`ifdef DEMUX_PAIR_ALIGN_EN
    hold_d   = hold_q;
`endif
    if (!active) begin
      state_d  = IDLE;
      drop_inc = {1'b0, valid_in};
`ifdef DEMUX_PAIR_ALIGN_EN
      // A half-built pair loses its partner when the link drops.
      if (state_q == EXP1) drop_inc = drop_inc + 2'd1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = EXP0;
          drop_inc = {1'b0, valid_in};
        end
        EXP0: if (valid_in) begin
`ifdef DEMUX_PAIR_ALIGN_EN
          hold_d   = data_in;
`else
          stg_d0_d = data_in;
          stg_v0_d = 1'b1;
`endif
          state_d  = EXP1;
        end
        EXP1: if (valid_in) begin
          stg_d1_d = data_in;
          stg_v1_d = 1'b1;
`ifdef DEMUX_PAIR_ALIGN_EN
          stg_d0_d = hold_q;
          stg_v0_d = 1'b1;
`endif
          state_d  = EXP0;
        end
        default: state_d = IDLE;
      endcase
    end

    drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, drop_inc};
    drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    sel_d      = (state_d == EXP1);

    // Second stage: staged words land on the lanes one edge after acceptance.
    lane_0_d  = stg_v0_q ? stg_d0_q : lane_0_q;
    lane_1_d  = stg_v1_q ? stg_d1_q : lane_1_q;
    valid_0_d = stg_v0_q;
    valid_1_d = stg_v1_q;
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      stg_d0_q   <= '0;
      stg_d1_q   <= '0;
      stg_v0_q   <= 1'b0;
      stg_v1_q   <= 1'b0;
      lane_0_q   <= '0;
      lane_1_q   <= '0;
      valid_0_q  <= 1'b0;
      valid_1_q  <= 1'b0;
      drop_cnt_q <= '0;
`ifdef DEMUX_PAIR_ALIGN_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      stg_d0_q   <= stg_d0_d;
      stg_d1_q   <= stg_d1_d;
      stg_v0_q   <= stg_v0_d;
      stg_v1_q   <= stg_v1_d;
      lane_0_q   <= lane_0_d;
      lane_1_q   <= lane_1_d;
      valid_0_q  <= valid_0_d;
      valid_1_q  <= valid_1_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef DEMUX_PAIR_ALIGN_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign lane_0   = lane_0_q;
  assign lane_1   = lane_1_q;
  assign valid_0  = valid_0_q;
  assign valid_1  = valid_1_q;
  assign sel      = sel_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_lanes_1a2.sv
// Bench for demux_lanes_1a2: directed scenarios plus random traffic against a word-count model.
module tb_demux_lanes_1a2;
`ifdef DEMUX_PAIR_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk_2f = 1'b0;
  logic        reset_L = 1'b0;
  logic        active = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1, sel;
  logic [7:0]  drop_cnt;

  demux_lanes_1a2 dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .active(active), .data_in(data_in),
    .valid_in(valid_in), .lane_0(lane_0), .valid_0(valid_0), .lane_1(lane_1),
    .valid_1(valid_1), .sel(sel), .drop_cnt(drop_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a link is either down or up; once up, the count of words accepted since
  // activation decides the lane (even -> lane 0, odd -> lane 1).
  bit          m_init = 0;
  bit          linked;
  int          accepted;
  int          drops;
  logic [31:0] held, pd0, pd1, e_lane0, e_lane1;
  bit          pv0, pv1, e_v0, e_v1, e_sel;

  always @(posedge clk_2f) begin
    if (!reset_L) begin
      m_init = 1; linked = 0; accepted = 0; drops = 0; held = '0;
      pv0 = 0; pv1 = 0; e_lane0 = '0; e_lane1 = '0; e_v0 = 0; e_v1 = 0;
    end else if (m_init) begin
      e_v0 = pv0; e_v1 = pv1;
      if (pv0) e_lane0 = pd0;
      if (pv1) e_lane1 = pd1;
      pv0 = 0; pv1 = 0;
      if (!active) begin
        if (valid_in) drops++;
        if (ALIGN && linked && (accepted % 2 == 1)) drops++;
        linked = 0; accepted = 0;
      end else if (!linked) begin
        if (valid_in) drops++;
        linked = 1; accepted = 0;
      end else if (valid_in) begin
        if (accepted % 2 == 0) begin
          if (ALIGN) held = data_in;
          else begin pd0 = data_in; pv0 = 1; end
        end else begin
          pd1 = data_in; pv1 = 1;
          if (ALIGN) begin pd0 = held; pv0 = 1; end
        end
        accepted++;
      end
      if (drops > 255) drops = 255;
    end
    e_sel = linked && (accepted % 2 == 1);
  end

  logic [31:0] q0[$], q1[$];
  int          both_cnt = 0;
  int          pulse_cnt = 0;

  always @(negedge clk_2f) begin
    if (m_init) begin
      check("lane_0", lane_0, e_lane0);
      check("lane_1", lane_1, e_lane1);
      check("valid_0", 32'(valid_0), 32'(e_v0));
      check("valid_1", 32'(valid_1), 32'(e_v1));
      check("sel", 32'(sel), 32'(e_sel));
      check("drop_cnt", 32'(drop_cnt), 32'(drops));
      if (valid_0) q0.push_back(lane_0);
      if (valid_1) q1.push_back(lane_1);
      if (valid_0 && valid_1) both_cnt++;
      if (valid_0 || valid_1) pulse_cnt++;
    end
  end

  task automatic drive(input bit a, input bit v, input logic [31:0] d);
    active = a; valid_in = v; data_in = d;
    @(negedge clk_2f);
  endtask

  initial begin
    // Reset state
    reset_L = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("rst_lane_0", lane_0, 32'h0);
    check("rst_lane_1", lane_1, 32'h0);
    check("rst_valid", 32'({valid_0, valid_1}), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    reset_L = 1'b1;

    // Back-to-back stream of four words
    drive(1, 0, 0);
    q0.delete(); q1.delete(); both_cnt = 0;
    drive(1, 1, 32'hA0000001);
    drive(1, 1, 32'hA0000002);
    drive(1, 1, 32'hA0000003);
    drive(1, 1, 32'hA0000004);
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
    check("stream_n0", q0.size(), 2);
    check("stream_n1", q1.size(), 2);
    if (q0.size() == 2) begin
      check("stream_l0a", q0[0], 32'hA0000001);
      check("stream_l0b", q0[1], 32'hA0000003);
    end
    if (q1.size() == 2) begin
      check("stream_l1a", q1[0], 32'hA0000002);
      check("stream_l1b", q1[1], 32'hA0000004);
    end
    check("stream_pairs", both_cnt, ALIGN ? 2 : 0);

    // Bubbles keep sel on lane 1
    drive(1, 1, 32'h11);
    check("bub_sel1", 32'(sel), 32'h1);
    drive(1, 0, 0);
    check("bub_sel2", 32'(sel), 32'h1);
    drive(1, 0, 0);
    check("bub_sel3", 32'(sel), 32'h1);
    drive(1, 1, 32'h22);
    drive(1, 0, 0);
    check("bub_lane1", lane_1, 32'h22);
    check("bub_valid1", 32'(valid_1), 32'h1);

    // Activation restart
    drive(1, 1, 32'h55);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(1, 1, 32'h66);
    check("react_sel", 32'(sel), 32'h1);
    drive(1, 1, 32'h77);
    drive(1, 0, 0);
    check("react_lane0", lane_0, 32'h66);
    check("react_lane1", lane_1, 32'h77);
    check("react_drop", 32'(drop_cnt), ALIGN ? 32'h1 : 32'h0);

    // Drop counter saturation
    reset_L = 1'b0;
    drive(0, 0, 0);
    reset_L = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 300; i++) drive(0, 1, $urandom);
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_pulses", pulse_cnt, 0);

    // Reset mid-stream
    drive(1, 0, 0);
    drive(1, 1, 32'hB1);
    reset_L = 1'b0;
    drive(1, 1, 32'hB2);
    check("mid_lane_0", lane_0, 32'h0);
    check("mid_lane_1", lane_1, 32'h0);
    check("mid_valid", 32'({valid_0, valid_1}), 32'h0);
    check("mid_sel", 32'(sel), 32'h0);
    check("mid_drop", 32'(drop_cnt), 32'h0);
    reset_L = 1'b1;
    drive(1, 0, 0);
    drive(1, 1, 32'hB3);
    check("mid_next_sel", 32'(sel), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset_L = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), $urandom);
    end
    reset_L = 1'b1;
    for (int i = 0; i < 1000; i++)
      drive(($urandom_range(0, 2) == 0), 1'b1, $urandom);
    drive(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_lanes_1a2.md
# demux_lanes_1a2

Two-lane word distributor on the `clk_2f` domain. It consumes the 32-bit word stream that the recirculation stage forwards on its active path (`demux_0` / `valid_out`). It deals consecutive valid words alternately onto lane 0 and lane 1 for the downstream per-lane serializers. It also tracks link activity so lane pairing restarts cleanly on every new activation and discarded words are counted.

## Interface
Parameters:
- `DATA_W`, 32, word width per lane.
- `CNT_W`, 8, width of the saturating drop counter.

Ports:
- `clk_2f`  in  1  sole clock; all state updates on its rising edge.
- `reset_L`  in  1  reset, synchronous and active-low.
- `active`  in  1  link active from upstream; low forces pairing back to lane 0.
- `data_in`  in  DATA_W  word from the recirculation stage's active output.
- `valid_in`  in  1  `data_in` qualifier.
- `lane_0`  out  DATA_W  lane 0 word, registered, held between updates.
- `valid_0`  out  1  one-cycle pulse; `lane_0` is new this cycle.
- `lane_1`  out  DATA_W  lane 1 word, registered, held between updates.
- `valid_1`  out  1  one-cycle pulse; `lane_1` is new this cycle.
- `sel`  out  1  lane that the next accepted word goes to (0/1).
- `drop_cnt`  out  CNT_W  saturating count of discarded words.

## Operation
- State machine states: IDLE, EXP0 (next word goes to lane 0), EXP1 (next word goes to lane 1). `sel` = 1 only in EXP1.
- IDLE -> EXP0 when `active`=1. Any state -> IDLE when `active`=0.
- In EXP0 with `valid_in`=1 and `active`=1: the word is accepted for lane 0 and the state moves to EXP1.
- In EXP1 with `valid_in`=1 and `active`=1: the word is accepted for lane 1 and the state moves to EXP0.
- `valid_in`=0: the state is held and no output is touched.
- A word is dropped when `valid_in`=1 while `active`=0, or while the state is IDLE (including the cycle `active` first rises). On each drop, `drop_cnt` increments by 1 and saturates at 2^CNT_W−1. It never wraps.
- When `valid_in` and an `active` fall arrive in the same cycle, the word is dropped. `active` is sampled in the same cycle as `valid_in`.
- `lane_0` and `lane_1` hold their last value indefinitely. Only the `valid_*` pulses mark new data.

## Timing
- Reset (`reset_L`=0 at an edge): state IDLE, `sel`=0, `lane_0`=`lane_1`=0, `valid_0`=`valid_1`=0, `drop_cnt`=0, hold register=0.
- Reset takes priority over all other inputs. Reset asserted mid-pair discards any half-built pair without counting it.
- Latency is 1 cycle (non-aligned mode): a word accepted at edge N appears on its lane with a valid pulse after edge N+1.
- Back-to-back valid words at full `clk_2f` rate are supported. With no bubbles, each lane produces at most one word every 2 cycles.
- There is no back-pressure. The block is always ready to accept.

## Configuration
- Macro: `DEMUX_PAIR_ALIGN_EN`.
- Defined (aligned mode):
  - A lane 0 word goes into an internal hold register. `valid_0` is not pulsed on its own.
  - When the lane 1 word is accepted at edge N, then after edge N+1: `lane_0`=held word, `lane_1`=new word, and `valid_0`=`valid_1`=1 in the same cycle.
  - If `active` falls while in EXP1, the held word is an orphan. It is discarded and `drop_cnt` increments by 1, in addition to any dropped input word that cycle. That can total +2 in one cycle, still saturating.
- Undefined: lanes update independently as described in Operation. There is no hold register and no orphan counting.

## Test plan
- Reset, then `active`=1 and the stream 0xA0000001, 0xA0000002, 0xA0000003, 0xA0000004 back-to-back -> lane_0 gets 0xA0000001 then 0xA0000003, lane_1 gets 0xA0000002 then 0xA0000004.
  - Without the macro: `valid_0` and `valid_1` alternate on consecutive cycles.
  - With the macro: `valid_0` and `valid_1` pulse together twice, 2 cycles apart.
- Bubbles: words 0x11 at edge 1 and 0x22 at edge 4, with `valid_in` low in between -> `sel` holds at 1 during edges 2–3, and 0x22 goes to lane 1.
- `active` dropped after a single word 0x55, then raised again, then word 0x66 -> 0x66 goes to lane 0. `drop_cnt` is 0 without the macro and 1 with it.
- `valid_in`=1 on every cycle for 300 cycles with `active`=0 -> `drop_cnt` saturates at 255 and no `valid_*` pulse occurs.
- `reset_L` pulsed low for one cycle in the middle of a stream -> all outputs read 0 after that edge, and the next accepted word goes to lane 0.
